emu_lsu: RTL and testbench
==========================

EMU_LSU -- requirements
Module: emu_lsu

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, byte address width; DATA_WIDTH, 32, data word width.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  load/store request present.
REQ-005 req_ready  output  1  request accepted this cycle when req_valid=1.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RV32 width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-008 req_addr  input  ADDR_WIDTH  byte address.
REQ-009 req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  DATA_WIDTH  extended load result; 0 for stores and errors.
REQ-012 rsp_err  output  1  request rejected, valid with rsp_valid.
REQ-013 mem_rwtyp, mem_addr, mem_data, mem_wren, mem_rden  output  3/ADDR_WIDTH/DATA_WIDTH/1/1  word-RAM port.
REQ-014 mem_q  input  DATA_WIDTH  RAM read data, valid the cycle after mem_rden, zero otherwise.

Function
REQ-015 States SHALL be IDLE, RD, WAIT, WR, RESP; req_ready=1 only in IDLE; request fields are registered on acceptance.
REQ-016 mem_rwtyp SHALL always be 3'b010 and mem_addr SHALL be {addr[31:2],2'b00}; all sub-word handling is internal.
REQ-017 Load: IDLE->RD (mem_rden=1) ->WAIT (capture mem_q at the WAIT->RESP edge) ->RESP; rsp_valid in 3rd cycle after acceptance.
REQ-018 Load extraction SHALL select lane addr[1:0] (byte) or addr[1] (half); LB/LH sign-extend, LBU/LHU zero-extend.
REQ-019 SW: IDLE->WR (mem_wren=1, mem_data=wdata) ->RESP; rsp_valid in 2nd cycle after acceptance.
REQ-020 SB/SH: read-modify-write IDLE->RD->WAIT->WR->RESP, merging wdata low bits into the captured word's selected lanes, other lanes unchanged; rsp_valid in 4th cycle.
REQ-021 mem_rden and mem_wren SHALL never be asserted together and are 0 outside RD/WR.
REQ-022 Invalid funct3 (011, 110, 111, or 100/101 with req_we=1) SHALL go IDLE->RESP with rsp_err=1, no memory access.
REQ-023 RESP SHALL last exactly one cycle, then IDLE; req_valid while busy is ignored (not accepted).

Reset
REQ-024 rstn low SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wren=0, mem_rden=0, mem_addr=0, mem_data=0, mem_rwtyp=3'b010.
REQ-025 Reset during RD/WAIT/WR SHALL abort the access with no response; a partially completed RMW writes nothing.

Configuration
REQ-026 With MISALIGN_TRAP_EN defined, halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL go IDLE->RESP with rsp_err=1, no memory access.
REQ-027 Without MISALIGN_TRAP_EN, misaligned low bits SHALL be ignored (half uses addr[1], word uses no lane bits) and only invalid funct3 raises rsp_err.

Structure
REQ-028 Package emu_lsu_pkg SHALL hold funct3 codes, the state enum, and RWTYP_WORD=3'b010.
REQ-029 Combinational sub-module emu_lsu_align SHALL perform load extraction/extension and store lane merge.

Verification
REQ-030 RAM word 0x100=0x8899AABB; LB 0x103 -> rsp_rdata=0xFFFFFF88; LBU 0x103 -> 0x00000088; rsp_valid 3 cycles after accept.
REQ-031 SH 0x00001234 at 0x102 -> word 0x100 becomes 0x1234AABB, one mem_rden then one mem_wren, rsp_valid 4 cycles after accept.
REQ-032 SW 0xDEADBEEF at 0x200 then LW 0x200 -> 0xDEADBEEF, no mem_rden during the store.
REQ-033 LW 0x102: with MISALIGN_TRAP_EN -> rsp_err=1, no mem strobes; without -> data of word 0x100, rsp_err=0.
REQ-034 rstn pulsed low in WAIT of SB 0x101 -> no mem_wren, no rsp_valid, req_ready=1; word 0x100 unchanged.
REQ-035 req_funct3=011 -> rsp_err=1, rsp_rdata=0 in cycle after accept; req_valid held during busy not double-accepted.

Source files
------------

// File: rtl/emu_lsu_pkg.sv
// emu_lsu_pkg -- shared definitions for the emu_lsu load/store unit.
//   * RV32 load/store funct3 width codes
//   * FSM state enum
//   * RWTYP_WORD: fixed access type presented on the word-RAM port
//   * funct3_legal(): funct3/direction legality check
package emu_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU (load only)
    localparam logic [2:0] F3_HU = 3'b101;  // LHU (load only)

    localparam logic [2:0] RWTYP_WORD = 3'b010;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    // Unsigned variants exist only for loads.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: funct3_legal = 1'b1;
            F3_BU, F3_HU:     funct3_legal = ~we;
            default:          funct3_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/emu_lsu_align.sv
// emu_lsu_align -- combinational sub-word lane handling for emu_lsu.
// Ports:
//   funct3     in   width code of the registered request
//   lane       in   addr[1:0] of the registered request
//   word       in   word read from RAM
//   wdata      in   right-aligned store data
//   load_data  out  selected lane, sign- or zero-extended (whole word for LW)
//   store_word out  word with the selected lane(s) replaced by wdata (wdata for SW)
module emu_lsu_align
    import emu_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            lane,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] store_word
);

    logic [4:0] byte_off;
    logic [4:0] half_off;
    logic [7:0] sel_byte;
    logic [15:0] sel_half;

    // Halfwords ignore addr[0]: the lane is chosen by addr[1] alone.
    assign byte_off = {lane, 3'b000};
    assign half_off = {lane[1], 4'b0000};
    assign sel_byte = word[byte_off +: 8];
    assign sel_half = word[half_off +: 16];

    always_comb begin
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
            F3_H:    load_data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
            F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
            default: load_data = word;
        endcase
    end

    always_comb begin
        store_word = word;
        case (funct3)
            F3_B:    store_word[byte_off +: 8]  = wdata[7:0];
            F3_H:    store_word[half_off +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/emu_lsu.sv
// emu_lsu -- RV32 load/store unit in front of a word-wide RAM.
// Sub-word stores are done as read-modify-write; sub-word loads are
// extracted and extended internally, so the RAM only sees word accesses.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned halfword
// and word accesses with rsp_err instead of ignoring the low address bits.
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr, req_wdata   request fields
//   rsp_valid, rsp_rdata, rsp_err   one-cycle completion pulse and result
//   mem_rwtyp, mem_addr, mem_data, mem_wren, mem_rden   word-RAM port
//   mem_q                           RAM read data, one cycle after mem_rden
module emu_lsu
    import emu_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [2:0]            mem_rwtyp,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
    output logic                  mem_rden,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    state_t                state;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [1:0]            lane_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  bad_req;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_word;

    assign mem_rwtyp = RWTYP_WORD;

    always_comb begin
        bad_req = ~funct3_legal(req_funct3, req_we);
`ifdef MISALIGN_TRAP_EN
        if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
            bad_req = 1'b1;
        if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
            bad_req = 1'b1;
`endif
    end

    emu_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3     (f3_q),
        .lane       (lane_q),
        .word       (mem_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_wren  <= 1'b0;
            mem_rden  <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            lane_q    <= 2'b00;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        lane_q    <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        if (bad_req) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            if (req_we && req_funct3 == F3_W) begin
                                // Full-word store needs no read.
                                state    <= WR;
                                mem_wren <= 1'b1;
                                mem_data <= req_wdata;
                            end else begin
                                // Loads and sub-word stores read first.
                                state    <= RD;
                                mem_rden <= 1'b1;
                            end
                        end
                    end
                end
                RD: begin
                    mem_rden <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // mem_q is valid now; consume it before it returns to zero.
                    if (we_q) begin
                        state    <= WR;
                        mem_wren <= 1'b1;
                        mem_data <= store_word;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= load_data;
                    end
                end
                WR: begin
                    mem_wren  <= 1'b0;
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    mem_wren  <= 1'b0;
                    mem_rden  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emu_lsu.sv
// tb_emu_lsu -- directed bench for emu_lsu with a behavioural word RAM
// and a scoreboard queue of expected responses.
module tb_emu_lsu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  mem_rwtyp;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic        mem_rden;
    logic [31:0] mem_q;

    always #5 clk = ~clk;

    emu_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_rwtyp  (mem_rwtyp),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_rden   (mem_rden),
        .mem_q      (mem_q)
    );

    // Word RAM: read data one cycle after mem_rden, zero otherwise.
    logic [31:0] ram [0:1023];
    logic        pl_we;
    logic [9:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_we)
            ram[pl_idx] <= pl_data;
        else if (mem_wren)
            ram[mem_addr[11:2]] <= mem_data;
        mem_q <= mem_rden ? ram[mem_addr[11:2]] : 32'h0;
    end

    int rd_cnt = 0;
    int wr_cnt = 0;
    int both_cnt = 0;
    int vld_cnt = 0;

    always @(negedge clk) begin
        if (mem_rden) rd_cnt++;
        if (mem_wren) wr_cnt++;
        if (mem_rden && mem_wren) both_cnt++;
        if (rsp_valid) vld_cnt++;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_we = 1'b1;
        pl_idx = addr[11:2];
        pl_data = data;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Drive one request, queue its expectation, then wait (bounded) for the
    // response and compare it against the popped expectation.
    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_lat, input int exp_rd, input int exp_wr,
                           input logic hold);
        exp_t e;
        int rd0, wr0, vld0, n;
        logic seen;
        @(negedge clk);
        check({tag, "_ready_idle"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wd;
        e.rdata = exp_rdata;
        e.err = exp_err;
        e.lat = exp_lat;
        e.rd = exp_rd;
        e.wr = exp_wr;
        sb_q.push_back(e);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        vld0 = vld_cnt;
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (!hold) req_valid = 1'b0;
            if (rsp_valid === 1'b1) seen = 1'b1;
            else if (n == 1) check({tag, "_busy_ready"}, req_ready, 1'b0);
        end
        req_valid = 1'b0;
        check({tag, "_rsp_seen"}, seen, 1'b1);
        if (seen) begin
            e = sb_q.pop_front();
            check({tag, "_rdata"}, rsp_rdata, e.rdata);
            check({tag, "_err"}, rsp_err, e.err);
            check({tag, "_latency"}, n, e.lat);
        end
        @(negedge clk);
        #1;
        check({tag, "_rsp_pulse"}, rsp_valid, 1'b0);
        check({tag, "_ready_after"}, req_ready, 1'b1);
        check({tag, "_rden_cnt"}, rd_cnt - rd0, e.rd);
        check({tag, "_wren_cnt"}, wr_cnt - wr0, e.wr);
        if (hold) begin
            repeat (5) @(negedge clk);
            #1;
            check({tag, "_single_rsp"}, vld_cnt - vld0, 1);
        end
    endtask

    initial begin
        int wr0, vld0;
        rstn = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        pl_we = 1'b0;
        pl_idx = 10'h0;
        pl_data = 32'h0;

        preload(32'h100, 32'h8899AABB);
        #1;
        check("rst_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", rsp_err, 1'b0);
        check("rst_wren", mem_wren, 1'b0);
        check("rst_rden", mem_rden, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_data", mem_data, 32'h0);
        check("rst_rwtyp", mem_rwtyp, 3'b010);
        @(negedge clk);
        rstn = 1'b1;

        // Loads from word 0x100 = 0x8899AABB
        run_req("lb_103",  1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF88, 1'b0, 3, 1, 0, 1'b0);
        check("rwtyp_const", mem_rwtyp, 3'b010);
        run_req("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h00000088, 1'b0, 3, 1, 0, 1'b0);
        run_req("lh_102",  1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF8899, 1'b0, 3, 1, 0, 1'b0);
        run_req("lhu_100", 1'b0, 3'b101, 32'h100, 32'h0, 32'h0000AABB, 1'b0, 3, 1, 0, 1'b0);
        run_req("lb_100",  1'b0, 3'b000, 32'h100, 32'h0, 32'hFFFFFFBB, 1'b0, 3, 1, 0, 1'b0);

        // Sub-word stores (read-modify-write)
        run_req("sh_102", 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 1'b0, 4, 1, 1, 1'b0);
        check("sh_102_ram", ram[10'h040], 32'h1234AABB);
        run_req("lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 32'h1234AABB, 1'b0, 3, 1, 0, 1'b0);
        run_req("sb_101", 1'b1, 3'b000, 32'h101, 32'hFFFFFF7F, 32'h0, 1'b0, 4, 1, 1, 1'b0);
        check("sb_101_ram", ram[10'h040], 32'h12347FBB);
        run_req("lb_101", 1'b0, 3'b000, 32'h101, 32'h0, 32'h0000007F, 1'b0, 3, 1, 0, 1'b0);

        // Full-word store then load back
        run_req("sw_200", 1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 1'b0);
        run_req("lw_200", 1'b0, 3'b010, 32'h200, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0, 1'b0);

        // Misaligned word load
`ifdef MISALIGN_TRAP_EN
        run_req("lw_102", 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b0);
`else
        run_req("lw_102", 1'b0, 3'b010, 32'h102, 32'h0, 32'h12347FBB, 1'b0, 3, 1, 0, 1'b0);
`endif

        // Reset in WAIT of SB 0x101 aborts the read-modify-write
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b000;
        req_addr = 32'h101;
        req_wdata = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        wr0 = wr_cnt;
        vld0 = vld_cnt;
        check("abort_ready", req_ready, 1'b1);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_wren", mem_wren, 1'b0);
        check("abort_rden", mem_rden, 1'b0);
        check("abort_addr", mem_addr, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("abort_no_write", wr_cnt - wr0, 0);
        check("abort_no_rsp", vld_cnt - vld0, 0);
        check("abort_ram", ram[10'h040], 32'h12347FBB);

        // Illegal funct3, request held high while busy
        run_req("f3_011",   1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b1);
        run_req("f3_110",   1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b0);
        run_req("shu_st",   1'b1, 3'b101, 32'h100, 32'hFFFF, 32'h0, 1'b1, 1, 0, 0, 1'b0);
        run_req("lw_hold",  1'b0, 3'b010, 32'h200, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0, 1'b1);
        check("ram_after_err", ram[10'h040], 32'h12347FBB);

        check("rden_wren_exclusive", both_cnt, 0);
        check("sb_queue_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
